// File: rtl/ask4_upsampler.sv
// ask4_upsampler: maps Gray-coded 2-bit symbols onto 4-ASK levels and emits
// them as an impulse train, one non-zero sample every UPSAMPLE clocks, with
// a one-entry holding buffer and an underflow pulse when a slot goes empty.
module ask4_upsampler #(
    parameter int UPSAMPLE  = 4,
    parameter int LVL_OUTER = 131070,
    parameter int LVL_INNER = 43690
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         sym_in,
    input  logic               sym_valid,
    output logic               sym_ready,
    output logic signed [17:0] sample_out,
    output logic               sym_strobe,
    output logic               underflow
);

    // Phase counter just wide enough for 0..UPSAMPLE-1 (UPSAMPLE is 2..16)
    localparam int PW = (UPSAMPLE > 2) ? $clog2(UPSAMPLE) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(UPSAMPLE - 1);

    // Exact 18-bit two's complement levels, no rounding or saturation
    localparam logic signed [17:0] POS_OUTER = 18'(LVL_OUTER);
    localparam logic signed [17:0] NEG_OUTER = 18'(-LVL_OUTER);
    localparam logic signed [17:0] POS_INNER = 18'(LVL_INNER);
    localparam logic signed [17:0] NEG_INNER = 18'(-LVL_INNER);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      phase_q, phase_d;
    logic [1:0]         buf_q, buf_d;
    logic               buf_full_q, buf_full_d;
    logic signed [17:0] sample_q, sample_d;
    logic               strobe_q, strobe_d;
    logic               underflow_q, underflow_d;

    logic               slot_zero;
    logic               accept;

    // Gray mapping: the two middle codes are the inner levels
    function automatic logic signed [17:0] map_sym(input logic [1:0] s);
        logic signed [17:0] lvl;
        case (s)
            2'b00:   lvl = NEG_OUTER;
            2'b01:   lvl = NEG_INNER;
            2'b11:   lvl = POS_INNER;
            default: lvl = POS_OUTER;
        endcase
        return lvl;
    endfunction

    // A symbol slot is the phase-0 edge while running; the buffer frees up there
    assign slot_zero  = (state_q == RUN) && (phase_q == '0);
    assign sym_ready  = !buf_full_q || slot_zero;
    assign accept     = sym_valid && sym_ready;

    assign sample_out = sample_q;
    assign sym_strobe = strobe_q;
    assign underflow  = underflow_q;

    // Next-state: FSM, phase counter, holding buffer and registered outputs
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        buf_d       = buf_q;
        buf_full_d  = buf_full_q;
        sample_d    = '0;
        strobe_d    = 1'b0;
        underflow_d = 1'b0;

        case (state_q)
            IDLE: begin
                phase_d = '0;
                if (accept) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + PW'(1);
                if (slot_zero) begin
                    if (buf_full_q) begin
                        sample_d   = map_sym(buf_q);
                        strobe_d   = 1'b1;
                        buf_full_d = 1'b0;
                    end else begin
                        underflow_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
            end
        endcase

        // Accept after consume so a same-edge refill leaves the buffer full
        if (accept) begin
            buf_d      = sym_in;
            buf_full_d = 1'b1;
        end
    end

    // State and output registers, cleared asynchronously by active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            buf_q       <= '0;
            buf_full_q  <= 1'b0;
            sample_q    <= '0;
            strobe_q    <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            buf_q       <= buf_d;
            buf_full_q  <= buf_full_d;
            sample_q    <= sample_d;
            strobe_q    <= strobe_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_ask4_upsampler.sv
// Testbench for ask4_upsampler: UPSAMPLE=4 and UPSAMPLE=8 instances checked
// against a slot/queue reference model and against fixed expected sequences.
module tb_ask4_upsampler;

    logic               clk;
    logic               reset;

    logic [1:0]         in4, in8;
    logic               valid4, valid8;
    logic               ready4, ready8;
    logic signed [17:0] out4, out8;
    logic               strobe4, strobe8;
    logic               uf4, uf8;

    ask4_upsampler #(.UPSAMPLE(4)) dut4 (
        .clk        (clk),
        .reset      (reset),
        .sym_in     (in4),
        .sym_valid  (valid4),
        .sym_ready  (ready4),
        .sample_out (out4),
        .sym_strobe (strobe4),
        .underflow  (uf4)
    );

    ask4_upsampler #(.UPSAMPLE(8)) dut8 (
        .clk        (clk),
        .reset      (reset),
        .sym_in     (in8),
        .sym_valid  (valid8),
        .sym_ready  (ready8),
        .sample_out (out8),
        .sym_strobe (strobe8),
        .underflow  (uf8)
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vecs  = 0;
    int fails = 0;
    bit sel8  = 1'b0;

    // Reference model: a symbol queue plus the absolute edge where slot 0 began
    int                 mU;
    bit                 mRunning;
    int                 mStart;
    int                 mEdge;
    logic [1:0]         mQ[$];
    logic signed [17:0] expOut;
    logic               expStrobe, expUf, expReady;

    logic signed [17:0] obsOut;
    logic               obsStrobe, obsUf, obsReady;

    logic signed [17:0] obsEmit[$];
    logic signed [17:0] expEmit[$];
    int                 strobeEdges[$];

    function automatic logic signed [17:0] refLevel(input logic [1:0] s);
        int v;
        case (s)
            2'b00:   v = -131070;
            2'b01:   v = -43690;
            2'b11:   v = 43690;
            default: v = 131070;
        endcase
        return 18'(v);
    endfunction

    task automatic modelReset(input int u);
        mU       = u;
        mRunning = 1'b0;
        mStart   = 0;
        mEdge    = 0;
        mQ.delete();
        obsEmit.delete();
        expEmit.delete();
        strobeEdges.delete();
    endtask

    // Entered at posedge+1; leaves at posedge+1 with reset released
    task automatic doReset(input int u);
        reset  = 1'b0;
        valid4 = 1'b0;
        valid8 = 1'b0;
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        modelReset(u);
    endtask

    // One clock: drive, sample ready, advance model and DUT, sample outputs
    task automatic doCycle(input bit v, input logic [1:0] s);
        bit slotZero;
        if (sel8) begin
            valid8 = v; in8 = s; valid4 = 1'b0;
        end else begin
            valid4 = v; in4 = s; valid8 = 1'b0;
        end
        #1;
        obsReady = sel8 ? ready8 : ready4;
        slotZero = mRunning && (((mEdge - mStart) % mU) == 0);
        expReady = (mQ.size() == 0) || slotZero;
        @(posedge clk);
        expOut    = '0;
        expStrobe = 1'b0;
        expUf     = 1'b0;
        if (slotZero) begin
            if (mQ.size() > 0) begin
                expOut    = refLevel(mQ.pop_front());
                expStrobe = 1'b1;
            end else begin
                expUf = 1'b1;
            end
        end
        if (v && expReady) begin
            mQ.push_back(s);
            expEmit.push_back(refLevel(s));
            if (!mRunning) begin
                mRunning = 1'b1;
                mStart   = mEdge + 1;
            end
        end
        mEdge++;
        #1;
        obsOut    = sel8 ? out8 : out4;
        obsStrobe = sel8 ? strobe8 : strobe4;
        obsUf     = sel8 ? uf8 : uf4;
        if (obsStrobe) begin
            obsEmit.push_back(obsOut);
            strobeEdges.push_back(mEdge - 1);
        end
    endtask

    // Reset values on both instances while reset is held low
    task automatic test_reset();
        vecs++;
        if ({out4, strobe4, uf4, ready4} !== {18'sd0, 1'b0, 1'b0, 1'b1}) begin
            fails++;
            $display("[TB] FAIL reset4 got out=%0d strobe=%b uf=%b ready=%b want 0 0 0 1",
                     out4, strobe4, uf4, ready4);
        end
        vecs++;
        if ({out8, strobe8, uf8, ready8} !== {18'sd0, 1'b0, 1'b0, 1'b1}) begin
            fails++;
            $display("[TB] FAIL reset8 got out=%0d strobe=%b uf=%b ready=%b want 0 0 0 1",
                     out8, strobe8, uf8, ready8);
        end
        reset = 1'b1;
        modelReset(4);
    endtask

    // Single symbol 10: latency one edge, three zeros, then underflow
    task automatic test_single();
        logic signed [17:0] wantOut[7];
        logic               wantUf[7];
        wantOut = '{18'sd0, 18'sd131070, 18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0};
        wantUf  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        sel8 = 1'b0;
        doReset(4);
        for (int e = 0; e < 7; e++) begin
            doCycle(e == 0, 2'b10);
            vecs++;
            if ({obsOut, obsStrobe, obsUf} !== {wantOut[e], wantOut[e] != 0, wantUf[e]}) begin
                fails++;
                $display("[TB] FAIL single edge%0d got out=%0d strobe=%b uf=%b want %0d %b %b",
                         e, obsOut, obsStrobe, obsUf, wantOut[e], wantOut[e] != 0, wantUf[e]);
            end
        end
    endtask

    // Continuous 00,01,11,10 gives a fixed impulse train with no underflow
    task automatic test_continuous();
        logic [1:0]         syms[4];
        logic signed [17:0] want[13];
        int                 idx;
        syms = '{2'b00, 2'b01, 2'b11, 2'b10};
        want = '{-18'sd131070, 18'sd0, 18'sd0, 18'sd0, -18'sd43690, 18'sd0, 18'sd0, 18'sd0,
                 18'sd43690, 18'sd0, 18'sd0, 18'sd0, 18'sd131070};
        sel8 = 1'b0;
        doReset(4);
        idx = 0;
        for (int e = 0; e < 14; e++) begin
            if (idx < 4) doCycle(1'b1, syms[idx]);
            else         doCycle(1'b0, 2'b00);
            if (idx < 4 && expReady) idx++;
            if (e >= 1) begin
                vecs++;
                if ({obsOut, obsUf} !== {want[e-1], 1'b0}) begin
                    fails++;
                    $display("[TB] FAIL continuous edge%0d got out=%0d uf=%b want %0d 0",
                             e, obsOut, obsUf, want[e-1]);
                end
            end
        end
    endtask

    // Held sym_valid under backpressure: model check each cycle, then no loss/dup
    task automatic test_backpressure();
        logic [1:0] cur;
        sel8 = 1'b0;
        doReset(4);
        cur = 2'($urandom_range(0, 3));
        for (int e = 0; e < 48; e++) begin
            if (e < 40) doCycle(1'b1, cur);
            else        doCycle(1'b0, 2'b00);
            if (e < 40 && expReady) cur = 2'($urandom_range(0, 3));
            vecs++;
            if ({obsOut, obsStrobe, obsUf, obsReady} !== {expOut, expStrobe, expUf, expReady}) begin
                fails++;
                $display("[TB] FAIL backpressure edge%0d got out=%0d s=%b u=%b r=%b want %0d %b %b %b",
                         e, obsOut, obsStrobe, obsUf, obsReady, expOut, expStrobe, expUf, expReady);
            end
        end
        vecs++;
        if (obsEmit.size() != expEmit.size()) begin
            fails++;
            $display("[TB] FAIL backpressure_count got %0d emitted want %0d accepted",
                     obsEmit.size(), expEmit.size());
        end else begin
            for (int i = 0; i < obsEmit.size(); i++) begin
                vecs++;
                if (obsEmit[i] !== expEmit[i]) begin
                    fails++;
                    $display("[TB] FAIL backpressure_order idx%0d got %0d want %0d",
                             i, obsEmit[i], expEmit[i]);
                end
            end
        end
    endtask

    // Two symbols then starvation: underflow every 4 cycles, late symbol on next slot
    task automatic test_starvation();
        int ufCount;
        sel8 = 1'b0;
        doReset(4);
        ufCount = 0;
        for (int e = 0; e < 26; e++) begin
            doCycle(e < 2 || e == 18, 2'($urandom_range(0, 3)));
            if (e >= 2 && e <= 17 && obsUf) ufCount++;
            vecs++;
            if ({obsOut, obsStrobe, obsUf, obsReady} !== {expOut, expStrobe, expUf, expReady}) begin
                fails++;
                $display("[TB] FAIL starvation edge%0d got out=%0d s=%b u=%b r=%b want %0d %b %b %b",
                         e, obsOut, obsStrobe, obsUf, obsReady, expOut, expStrobe, expUf, expReady);
            end
        end
        vecs++;
        if (ufCount != 3) begin
            fails++;
            $display("[TB] FAIL starvation_uf got %0d pulses want 3", ufCount);
        end
        vecs++;
        if (strobeEdges.size() != 3 || strobeEdges[2] != 21) begin
            fails++;
            $display("[TB] FAIL starvation_late got %0d strobes (last edge %0d) want 3 with last at 21",
                     strobeEdges.size(), strobeEdges.size() > 0 ? strobeEdges[$] : -1);
        end
    endtask

    // Reset at phase 2 with a full buffer: async clear, pending symbol dropped
    task automatic test_reset_mid();
        int strobes;
        sel8 = 1'b0;
        doReset(4);
        doCycle(1'b1, 2'b00);
        doCycle(1'b1, 2'b10);
        doCycle(1'b0, 2'b00);
        #1;
        vecs++;
        if (ready4 !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midreset_pre got ready=%b want 0", ready4);
        end
        reset = 1'b0;
        #1;
        vecs++;
        if ({out4, strobe4, uf4, ready4} !== {18'sd0, 1'b0, 1'b0, 1'b1}) begin
            fails++;
            $display("[TB] FAIL midreset_async got out=%0d strobe=%b uf=%b ready=%b want 0 0 0 1",
                     out4, strobe4, uf4, ready4);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        modelReset(4);
        strobes = 0;
        for (int e = 0; e < 12; e++) begin
            doCycle(1'b0, 2'b00);
            if (obsStrobe || obsUf) strobes++;
        end
        vecs++;
        if (strobes != 0) begin
            fails++;
            $display("[TB] FAIL midreset_after got %0d active cycles want 0", strobes);
        end
    endtask

    // Random valid/symbol traffic against the model
    task automatic test_random(input bit use8, input int cycles);
        sel8 = use8;
        doReset(use8 ? 8 : 4);
        for (int e = 0; e < cycles; e++) begin
            doCycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            vecs++;
            if ({obsOut, obsStrobe, obsUf, obsReady} !== {expOut, expStrobe, expUf, expReady}) begin
                fails++;
                $display("[TB] FAIL random%0d edge%0d got out=%0d s=%b u=%b r=%b want %0d %b %b %b",
                         mU, e, obsOut, obsStrobe, obsUf, obsReady, expOut, expStrobe, expUf, expReady);
            end
        end
    endtask

    // UPSAMPLE=8: strobes 8 cycles apart, same level mapping
    task automatic test_upsample8();
        logic [1:0]         syms[4];
        logic signed [17:0] want[4];
        int                 idx;
        syms = '{2'b10, 2'b00, 2'b11, 2'b01};
        want = '{18'sd131070, -18'sd131070, 18'sd43690, -18'sd43690};
        sel8 = 1'b1;
        doReset(8);
        idx = 0;
        for (int e = 0; e < 30; e++) begin
            if (idx < 4) doCycle(1'b1, syms[idx]);
            else         doCycle(1'b0, 2'b00);
            if (idx < 4 && expReady) idx++;
        end
        vecs++;
        if (strobeEdges.size() != 4) begin
            fails++;
            $display("[TB] FAIL up8_count got %0d strobes want 4", strobeEdges.size());
        end else begin
            vecs++;
            if (strobeEdges[0] != 1) begin
                fails++;
                $display("[TB] FAIL up8_latency got edge %0d want 1", strobeEdges[0]);
            end
            for (int i = 0; i < 4; i++) begin
                vecs++;
                if (obsEmit[i] !== want[i]) begin
                    fails++;
                    $display("[TB] FAIL up8_level idx%0d got %0d want %0d", i, obsEmit[i], want[i]);
                end
                if (i > 0) begin
                    vecs++;
                    if (strobeEdges[i] - strobeEdges[i-1] != 8) begin
                        fails++;
                        $display("[TB] FAIL up8_spacing idx%0d got %0d want 8",
                                 i, strobeEdges[i] - strobeEdges[i-1]);
                    end
                end
            end
        end
    endtask

    // Hard time limit so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Test sequence
    initial begin
        reset  = 1'b0;
        valid4 = 1'b0;
        valid8 = 1'b0;
        in4    = 2'b00;
        in8    = 2'b00;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_continuous();
        test_backpressure();
        test_starvation();
        test_reset_mid();
        test_random(1'b0, 300);
        test_upsample8();
        test_random(1'b1, 200);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule

// File: doc/ask4_upsampler.md
ASK4_UPSAMPLER -- requirements
Module: ask4_upsampler

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  UPSAMPLE   4          samples per symbol; legal values 2..16
  LVL_OUTER  131070     magnitude of outer 4-ASK level, signed 1s17
  LVL_INNER  43690      magnitude of inner 4-ASK level, signed 1s17
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low. Ports, one per line: name, direction, width, meaning.
  clk         in   1   sample clock, rising edge
  reset       in   1   asynchronous, active-low reset
  sym_in      in   2   Gray-coded symbol bits
  sym_valid   in   1   sym_in valid
  sym_ready   out  1   block can accept a symbol this cycle
  sample_out  out  18  signed 1s17 upsampled impulse train; feeds srrc_tx_flt input
  sym_strobe  out  1   high on the cycle sample_out carries a symbol
  underflow   out  1   one-cycle pulse: symbol slot reached with empty buffer

Function
REQ-003 The block SHALL contain a 2-state FSM: IDLE, RUN.
REQ-004 In IDLE: phase counter held at 0; sample_out=0; sym_strobe=0; underflow=0.
REQ-005 IDLE->RUN SHALL occur on the edge where sym_valid&&sym_ready; RUN SHALL be left only by reset.
REQ-006 In RUN, phase_q SHALL increment every edge and wrap from UPSAMPLE-1 to 0.
REQ-007 A one-entry holding register (buf, buf_full) SHALL store the accepted symbol.
REQ-008 sym_ready SHALL be combinational: !buf_full || (state==RUN && phase_q==0).
REQ-009 Accept = sym_valid && sym_ready; on accept buf<=sym_in, buf_full<=1.
REQ-010 On an edge in RUN with phase_q==0 and buf_full: sample_out<=map(buf), sym_strobe<=1, buf consumed.
REQ-011 Simultaneous consume and accept on one edge SHALL leave buf_full=1 holding the new symbol.
REQ-012 On an edge in RUN with phase_q==0 and !buf_full: sample_out<=0, sym_strobe<=0, underflow<=1; phase continues.
REQ-013 On all other edges: sample_out<=0, sym_strobe<=0, underflow<=0.
REQ-014 Mapping SHALL be: 00 -> -LVL_OUTER, 01 -> -LVL_INNER, 11 -> +LVL_INNER, 10 -> +LVL_OUTER.
REQ-015 Mapped values SHALL be exact 18-bit two's complement with no rounding or saturation; parameters SHALL satisfy LVL_OUTER <= 131071.
REQ-016 Latency from IDLE: symbol accepted at edge N SHALL appear on sample_out after edge N+1.
REQ-017 In steady RUN, sample_out non-zero samples SHALL be spaced exactly UPSAMPLE cycles apart.
REQ-018 sym_valid with sym_ready low SHALL be ignored; sym_in is not sampled.

Reset
REQ-019 reset low SHALL asynchronously force: state=IDLE, phase_q=0, buf_full=0, sample_out=0, sym_strobe=0, underflow=0.
REQ-020 sym_ready SHALL read 1 while reset is low.
REQ-021 Reset asserted mid-symbol SHALL discard the buffered symbol; after release the block SHALL restart from IDLE.
REQ-022 Reset release SHALL take effect at the first rising clk edge after reset goes high.

Verification
REQ-023 Bench SHALL cover:
  a) Reset, then one symbol 10 at edge N -> sample_out=+131070, sym_strobe=1 after edge N+1; 0 for the next 3 cycles; underflow=1 after edge N+5.
  b) Continuous sym_valid with 00,01,11,10 -> sample_out sequence -131070,0,0,0,-43690,0,0,0,+43690,0,0,0,+131070; no underflow.
  c) Backpressure -> sym_ready=0 for phases 1..3 with buf_full=1; held sym_in accepted only at phase 0; no symbol lost or duplicated.
  d) Starvation after 2 symbols -> underflow pulses every 4 cycles; next symbol emitted at the next phase 0.
  e) reset low during phase 2 with buf_full=1 -> all outputs 0 immediately; after release the pending symbol is never emitted.
  f) UPSAMPLE=8 -> symbol spacing is 8 cycles; mapping unchanged.
